axi_inject_sched: RTL and testbench

// - Synthesizable timestamp scheduler in front of an AXI manager port; replaces per-cycle timestep matching in injection benches.
// - A loader pushes timestamped AW/W/AR entries into three per-channel FIFOs.
// - The block releases each FIFO head onto its AXI channel once a run-cycle counter reaches the entry timestamp.
// - It holds valid until the handshake completes, optionally gates W behind AW, and reports completion/lateness.

---
 rtl/axi_inject_sched.sv | 151 +++++++++++++++
 tb/tb_axi_inject_sched.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_inject_sched.sv
// axi_inject_sched: releases timestamped AW/W/AR entries onto an AXI manager port when the run counter reaches them
module axi_inject_sched #(
    parameter int unsigned Depth     = 4,
    parameter int unsigned TimeWidth = 32,
    parameter bit          WAfterAw  = 1'b1,
    parameter type         aw_chan_t = logic,
    parameter type         w_chan_t  = struct packed { logic last; },
    parameter type         ar_chan_t = logic
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 start_i,
    input  logic                 pause_i,
    input  logic                 finish_i,
    input  logic                 push_valid_i,
    output logic                 push_ready_o,
    input  logic [1:0]           push_chan_i,
    input  logic [TimeWidth-1:0] push_time_i,
    input  aw_chan_t             push_aw_i,
    input  w_chan_t              push_w_i,
    input  ar_chan_t             push_ar_i,
    output logic                 aw_valid_o,
    output aw_chan_t             aw_o,
    input  logic                 aw_ready_i,
    output logic                 w_valid_o,
    output w_chan_t              w_o,
    input  logic                 w_ready_i,
    output logic                 ar_valid_o,
    output ar_chan_t             ar_o,
    input  logic                 ar_ready_i,
    output logic [TimeWidth-1:0] time_o,
    output logic [15:0]          late_cnt_o,
    output logic                 busy_o,
    output logic                 done_o
);
    localparam int unsigned PW = $clog2(Depth);
    localparam int unsigned CW = PW + 2;

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

    state_t               state, state_next;
    logic [TimeWidth-1:0] cnt;
    logic [TimeWidth-1:0] tmem [3][Depth];
    aw_chan_t             aw_mem [Depth];
    w_chan_t              w_mem [Depth];
    ar_chan_t             ar_mem [Depth];
    logic [PW:0]          wp [3];
    logic [PW:0]          rp [3];
    logic [TimeWidth-1:0] head_t [3];
    logic [2:0]           empty, full, vld, rdy, hs, elig, late, gate;
    logic [3:0]           full4;
    logic [CW-1:0]        credit;
    logic [15:0]          late_q;
    logic [17:0]          late_sum;
    logic                 fin, run_en, start_ok, push_en, w_last_hs;

    // Channel index 0=AW 1=W 2=AR throughout; chan 3 maps to a never-full slot so it is always accepted
    assign rdy       = {ar_ready_i, w_ready_i, aw_ready_i};
    assign hs        = vld & rdy;
    assign run_en    = state == RUN && !pause_i;
    assign start_ok  = start_i && (state == IDLE || state == DONE);
    assign w_last_hs = hs[1] && w_o.last;
    assign full4     = {1'b0, full};
    assign push_ready_o = rst_ni && state != DONE && !full4[push_chan_i];
    assign push_en   = push_valid_i && push_ready_o;
    // An AW handshake in flight already counts as credit so W may follow on the very next cycle
    assign gate      = {1'b1, !WAfterAw || credit != '0 || hs[0], credit != '1};
    assign late_sum  = 18'(late_q) + 18'(late[0]) + 18'(late[1]) + 18'(late[2]);

    // Per-channel FIFO status and issue eligibility of each head entry
    always_comb begin
        for (int c = 0; c < 3; c++) begin
            empty[c]  = wp[c] == rp[c];
            full[c]   = (wp[c] - rp[c]) == (PW+1)'(Depth);
            head_t[c] = tmem[c][rp[c][PW-1:0]];
            elig[c]   = run_en && !empty[c] && !vld[c] && head_t[c] <= cnt && gate[c];
            late[c]   = elig[c] && cnt > head_t[c];
        end
    end

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state <= IDLE;
        else         state <= state_next;
    end

    // Next-state logic; finishing requires every FIFO, valid and outstanding AW burst to be drained
    always_comb begin
        state_next = state;
        case (state)
            IDLE:  state_next = start_i ? RUN : IDLE;
            RUN:   state_next = pause_i ? PAUSE :
                                (fin && empty == '1 && vld == '0 && credit == '0) ? DONE : RUN;
            PAUSE: state_next = pause_i ? PAUSE : RUN;
            DONE:  state_next = start_i ? RUN : DONE;
        endcase
    end

    // Run counter, finish flag, lateness, AW credit and registered channel valids
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt    <= '0;
            fin    <= 1'b0;
            late_q <= '0;
            credit <= '0;
            vld    <= '0;
        end else begin
            if (start_ok) cnt <= '0;
            else if (run_en && cnt != '1) cnt <= cnt + 1'b1;
            fin    <= finish_i || (fin && !start_ok);
            late_q <= late_sum > 18'h0FFFF ? 16'hFFFF : late_sum[15:0];
            credit <= credit + CW'(hs[0]) - CW'(w_last_hs);
            vld    <= (vld & ~rdy) | elig;
        end
    end

    // FIFO pointers: push on accepted loader entry, pop on channel handshake
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int c = 0; c < 3; c++) begin
                wp[c] <= '0;
                rp[c] <= '0;
            end
        end else begin
            for (int c = 0; c < 3; c++) begin
                if (push_en && push_chan_i == 2'(c)) wp[c] <= wp[c] + 1'b1;
                if (hs[c]) rp[c] <= rp[c] + 1'b1;
            end
        end
    end

    // FIFO storage; contents need no reset because pointers define occupancy
    always_ff @(posedge clk_i) begin
        for (int c = 0; c < 3; c++)
            if (push_en && push_chan_i == 2'(c)) tmem[c][wp[c][PW-1:0]] <= push_time_i;
        if (push_en && push_chan_i == 2'd0) aw_mem[wp[0][PW-1:0]] <= push_aw_i;
        if (push_en && push_chan_i == 2'd1) w_mem[wp[1][PW-1:0]] <= push_w_i;
        if (push_en && push_chan_i == 2'd2) ar_mem[wp[2][PW-1:0]] <= push_ar_i;
    end

    assign aw_valid_o = vld[0];
    assign w_valid_o  = vld[1];
    assign ar_valid_o = vld[2];
    assign aw_o       = aw_mem[rp[0][PW-1:0]];
    assign w_o        = w_mem[rp[1][PW-1:0]];
    assign ar_o       = ar_mem[rp[2][PW-1:0]];
    assign time_o     = cnt;
    assign late_cnt_o = late_q;
    assign busy_o     = state == RUN || state == PAUSE;
    assign done_o     = state == DONE;
endmodule

// File: tb/tb_axi_inject_sched.sv
// tb_axi_inject_sched: directed scenarios with a scoreboard monitor checking issue and handshake timing
module tb_axi_inject_sched;
    typedef logic [7:0] aw_t;
    typedef struct packed { logic [6:0] data; logic last; } w_t;
    typedef logic [7:0] ar_t;
    typedef struct { int ch; logic [7:0] pay; int rise; int hs; } exp_t;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        start_i = 1'b0, pause_i = 1'b0, finish_i = 1'b0;
    logic        push_valid_i = 1'b0, push_ready_o;
    logic [1:0]  push_chan_i = '0;
    logic [31:0] push_time_i = '0;
    aw_t         push_aw_i = '0, aw_o;
    w_t          push_w_i = '0, w_o;
    ar_t         push_ar_i = '0, ar_o;
    logic        aw_valid_o, w_valid_o, ar_valid_o;
    logic        aw_ready_i = 1'b0, w_ready_i = 1'b0, ar_ready_i = 1'b0;
    logic [31:0] time_o;
    logic [15:0] late_cnt_o;
    logic        busy_o, done_o;

    int   checks = 0;
    int   failures = 0;
    exp_t sb[$];
    logic [2:0] pv = '0, ph = '0;
    logic [7:0] pp [3];

    axi_inject_sched #(
        .Depth(4), .TimeWidth(32), .WAfterAw(1'b1),
        .aw_chan_t(aw_t), .w_chan_t(w_t), .ar_chan_t(ar_t)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .pause_i(pause_i), .finish_i(finish_i),
        .push_valid_i(push_valid_i), .push_ready_o(push_ready_o), .push_chan_i(push_chan_i),
        .push_time_i(push_time_i), .push_aw_i(push_aw_i), .push_w_i(push_w_i), .push_ar_i(push_ar_i),
        .aw_valid_o(aw_valid_o), .aw_o(aw_o), .aw_ready_i(aw_ready_i),
        .w_valid_o(w_valid_o), .w_o(w_o), .w_ready_i(w_ready_i),
        .ar_valid_o(ar_valid_o), .ar_o(ar_o), .ar_ready_i(ar_ready_i),
        .time_o(time_o), .late_cnt_o(late_cnt_o), .busy_o(busy_o), .done_o(done_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", n, act, exp);
        end
    endtask

    function automatic int find(input int ch);
        for (int i = 0; i < sb.size(); i++)
            if (sb[i].ch == ch) return i;
        return -1;
    endfunction

    // Monitor: valids must hold until ready, payload stable, a gap after each pop, and
    // rise/handshake must land on the expected counter values
    always @(negedge clk_i) begin
        logic [2:0] v, r;
        logic [7:0] p [3];
        int k;
        v = {ar_valid_o, w_valid_o, aw_valid_o};
        r = {ar_ready_i, w_ready_i, aw_ready_i};
        p[0] = aw_o; p[1] = w_o; p[2] = ar_o;
        if (!rst_ni) begin
            pv = '0;
            ph = '0;
        end else begin
            for (int c = 0; c < 3; c++) begin
                if (pv[c] && !ph[c]) begin
                    chk($sformatf("hold_ch%0d", c), 32'(v[c]), 1);
                    chk($sformatf("stable_ch%0d", c), 32'(p[c]), 32'(pp[c]));
                end
                if (ph[c]) chk($sformatf("gap_ch%0d", c), 32'(v[c]), 0);
                if (v[c] && !pv[c]) begin
                    k = find(c);
                    chk($sformatf("expected_rise_ch%0d", c), 32'(k >= 0), 1);
                    if (k >= 0) chk($sformatf("rise_time_ch%0d", c), time_o, sb[k].rise);
                end
                if (v[c] && r[c]) begin
                    k = find(c);
                    chk($sformatf("expected_hs_ch%0d", c), 32'(k >= 0), 1);
                    if (k >= 0) begin
                        chk($sformatf("payload_ch%0d", c), 32'(p[c]), 32'(sb[k].pay));
                        chk($sformatf("hs_time_ch%0d", c), time_o, sb[k].hs);
                        sb.delete(k);
                    end
                end
            end
            pv = v;
            ph = v & r;
            for (int c = 0; c < 3; c++) pp[c] = p[c];
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        {start_i, pause_i, finish_i, push_valid_i} = '0;
        {aw_ready_i, w_ready_i, ar_ready_i} = '0;
        sb.delete();
        tick();
        tick();
        rst_ni = 1'b1;
        tick();
    endtask

    task automatic push(input logic [1:0] ch, input int t, input logic [7:0] pay, output logic acc);
        push_valid_i = 1'b1;
        push_chan_i  = ch;
        push_time_i  = t;
        push_aw_i    = pay;
        push_w_i     = w_t'(pay);
        push_ar_i    = pay;
        #1 acc = push_ready_o;
        @(posedge clk_i);
        #1 push_valid_i = 1'b0;
    endtask

    task automatic start();
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
    endtask

    task automatic wait_time(input int t);
        int n = 0;
        while (time_o != t && n < 200) begin
            tick();
            n++;
        end
        chk("wait_time", time_o, t);
    endtask

    task automatic drain(input string n);
        tick();
        tick();
        chk(n, sb.size(), 0);
    endtask

    initial begin
        logic acc;
        int   n;
        // reset values while reset is held
        #3;
        chk("rst_time", time_o, 0);
        chk("rst_late", 32'(late_cnt_o), 0);
        chk("rst_busy", 32'(busy_o), 0);
        chk("rst_done", 32'(done_o), 0);
        chk("rst_valids", 32'({aw_valid_o, w_valid_o, ar_valid_o}), 0);
        chk("rst_push_ready", 32'(push_ready_o), 0);
        do_reset();

        // on-time AW issue, one-cycle valid at time 6
        aw_ready_i = 1'b1;
        push(2'd0, 5, 8'hA5, acc);
        chk("s1_accept", 32'(acc), 1);
        sb.push_back('{ch: 0, pay: 8'hA5, rise: 6, hs: 6});
        start();
        chk("s1_start_time", time_o, 0);
        wait_time(10);
        chk("s1_late", 32'(late_cnt_o), 0);
        drain("s1_drain");

        // back-pressured AW held from time 4 through 10
        do_reset();
        push(2'd0, 3, 8'h3C, acc);
        sb.push_back('{ch: 0, pay: 8'h3C, rise: 4, hs: 10});
        start();
        wait_time(10);
        aw_ready_i = 1'b1;
        tick();
        aw_ready_i = 1'b0;
        chk("s2_late", 32'(late_cnt_o), 0);
        drain("s2_drain");

        // AR FIFO full without start; reserved and other channels still accept
        do_reset();
        for (int i = 0; i < 4; i++) begin
            push(2'd2, i, 8'(i), acc);
            chk("s4_ar_accept", 32'(acc), 1);
        end
        push(2'd2, 9, 8'h99, acc);
        chk("s4_ar_full", 32'(acc), 0);
        push(2'd0, 1, 8'h11, acc);
        chk("s4_aw_accept", 32'(acc), 1);
        push(2'd3, 1, 8'h22, acc);
        chk("s4_ch3_accept", 32'(acc), 1);
        drain("s4_no_issue");

        // pause freezes the counter; AR at time 4 issues at time 5 afterwards
        do_reset();
        ar_ready_i = 1'b1;
        push(2'd2, 4, 8'h44, acc);
        sb.push_back('{ch: 2, pay: 8'h44, rise: 5, hs: 5});
        start();
        wait_time(2);
        pause_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("s5_pause_time", time_o, 2);
            chk("s5_pause_busy", 32'(busy_o), 1);
        end
        pause_i = 1'b0;
        wait_time(8);
        chk("s5_late", 32'(late_cnt_o), 0);
        drain("s5_drain");

        // W gated behind AW, then finish, restart and asynchronous reset mid-valid
        do_reset();
        aw_ready_i = 1'b1;
        w_ready_i  = 1'b1;
        push(2'd1, 0, 8'h23, acc);
        push(2'd0, 8, 8'h81, acc);
        sb.push_back('{ch: 1, pay: 8'h23, rise: 10, hs: 10});
        sb.push_back('{ch: 0, pay: 8'h81, rise: 9, hs: 9});
        start();
        wait_time(14);
        chk("s3_late", 32'(late_cnt_o), 1);
        finish_i = 1'b1;
        tick();
        finish_i = 1'b0;
        n = 0;
        while (!done_o && n < 20) begin
            tick();
            n++;
        end
        chk("s6_done", 32'(done_o), 1);
        chk("s6_done_busy", 32'(busy_o), 0);
        chk("s6_drain", sb.size(), 0);
        start();
        chk("s6_restart_time", time_o, 0);
        chk("s6_restart_busy", 32'(busy_o), 1);
        chk("s6_restart_done", 32'(done_o), 0);
        ar_ready_i = 1'b0;
        push(2'd2, 0, 8'h5A, acc);
        sb.push_back('{ch: 2, pay: 8'h5A, rise: 2, hs: -1});
        tick();
        chk("s6_ar_valid", 32'(ar_valid_o), 1);
        #2 rst_ni = 1'b0;
        #1;
        chk("s6_async_valids", 32'({aw_valid_o, w_valid_o, ar_valid_o}), 0);
        chk("s6_async_push_ready", 32'(push_ready_o), 0);
        sb.delete();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
